// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the RV32I datapath and a word-wide data-memory bus.
// Handshake: mem_req is held with stable bus fields until mem_ready=1 or timeout.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_readdata;

  logic        w_valid;
  logic        w_f3_ok;
  logic        w_aligned;
  logic        w_legal;
  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load;

  assign w_valid = memread ^ memwrite;

  always_comb begin
    w_f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = memread;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_legal = w_valid & w_f3_ok & w_aligned;
  // Any request that cannot go to the bus retires immediately with a zero result.
  assign w_bad   = (memread | memwrite) & ~w_legal;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    if (memwrite) begin
      case (funct3)
        3'b000: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        3'b001: begin
          w_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b101:  w_load = {16'd0, w_lane[15:0]};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_readdata <= 32'd0;
      err        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_legal) begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
            r_funct3  <= funct3;
            r_off     <= addr[1:0];
            r_cnt     <= 8'd0;
            r_state   <= BUSY;
          end else if (w_bad) begin
            err <= 1'b1;
          end
        end
        BUSY: begin
          // A completion in the last allowed cycle takes priority over the timeout.
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) r_readdata <= w_load;
            r_state <= DONE;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            mem_req    <= 1'b0;
            r_readdata <= 32'd0;
            err        <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall       = ~reset & ((r_state == BUSY) | ((r_state == IDLE) & w_legal));
  assign readdata    = ((r_state == IDLE) & w_bad) ? 32'd0 : r_readdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised and directed bench for lsu_mem_ctrl against a size/offset arithmetic model.
module tb_lsu_mem_ctrl;
  localparam int TO = 4;

  logic        clk, reset, memread, memwrite, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] readdata, mem_addr, mem_wdata;
  logic        stall, err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [1:0]  o_dbg_state;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_rd;
  logic        exp_err;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .readdata(readdata),
    .stall(stall), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .o_dbg_state(o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int access_size(input logic rd, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return rd ? 1 : 0;
      3'd5: return rd ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    int sz;
    if (rd == wr) return 1'b0;
    sz = access_size(rd, f3);
    if (sz == 0) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = a % 4;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdat);
    logic [31:0] lane, b, h;
    lane = rdat >> (8 * (a % 4));
    b = lane & 32'hFF;
    h = lane & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return rdat;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_rd = 32'd0; exp_err = 1'b0;
  endtask

  // lat = BUSY cycle in which mem_ready is given; lat outside 1..TO means never.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int lat);
    bit legal, timed_out, done;
    int cyc;
    @(posedge clk); #1;
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd; mem_ready = 1'b0;
    #1;
    legal = model_legal(rd, wr, f3, a);
    if (!legal) begin
      if (rd | wr) begin
        n_checks++;
        if (stall !== 1'b0) begin n_errors++; $display("FAIL bad_stall got %b exp 0", stall); end
        n_checks++;
        if (readdata !== 32'd0) begin n_errors++; $display("FAIL bad_readdata got %h exp 0", readdata); end
        exp_err = 1'b1;
      end
      @(posedge clk); #1;
      memread = 1'b0; memwrite = 1'b0;
      #1;
      n_checks++;
      if (err !== exp_err) begin n_errors++; $display("FAIL bad_err got %b exp %b", err, exp_err); end
      n_checks++;
      if (mem_req !== 1'b0) begin n_errors++; $display("FAIL bad_no_req got %b exp 0", mem_req); end
      return;
    end
    n_checks++;
    if (stall !== 1'b1) begin n_errors++; $display("FAIL req_stall got %b exp 1", stall); end
    n_checks++;
    if (readdata !== exp_rd) begin n_errors++; $display("FAIL req_hold_rd got %h exp %h", readdata, exp_rd); end
    @(posedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b1) begin n_errors++; $display("FAIL busy_req got %b exp 1", mem_req); end
    n_checks++;
    if (mem_we !== wr) begin n_errors++; $display("FAIL busy_we got %b exp %b", mem_we, wr); end
    n_checks++;
    if (mem_addr !== (a & 32'hFFFFFFFC)) begin
      n_errors++; $display("FAIL busy_addr got %h exp %h", mem_addr, a & 32'hFFFFFFFC);
    end
    n_checks++;
    if (mem_be !== (wr ? model_be(f3, a) : 4'hF)) begin
      n_errors++; $display("FAIL busy_be got %b exp %b", mem_be, wr ? model_be(f3, a) : 4'hF);
    end
    if (wr) begin
      n_checks++;
      if (mem_wdata !== model_wdata(f3, wd)) begin
        n_errors++; $display("FAIL busy_wdata got %h exp %h", mem_wdata, model_wdata(f3, wd));
      end
    end
    timed_out = 1'b1; done = 1'b0; cyc = 1;
    while (!done) begin
      mem_ready = (cyc == lat);
      mem_rdata = (cyc == lat) ? rdat : $urandom;
      #1;
      n_checks++;
      if (stall !== 1'b1 || mem_req !== 1'b1) begin
        n_errors++; $display("FAIL busy_hold cyc %0d got stall %b req %b exp 1 1", cyc, stall, mem_req);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (cyc == lat) begin timed_out = 1'b0; done = 1'b1; end
      else if (cyc == TO) done = 1'b1;
      cyc++;
    end
    if (timed_out) begin exp_rd = 32'd0; exp_err = 1'b1; end
    else if (!wr) exp_rd = model_load(f3, a, rdat);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL done_stall got %b exp 0", stall); end
    n_checks++;
    if (mem_req !== 1'b0) begin n_errors++; $display("FAIL done_req got %b exp 0", mem_req); end
    n_checks++;
    if (readdata !== exp_rd) begin n_errors++; $display("FAIL done_readdata got %h exp %h", readdata, exp_rd); end
    n_checks++;
    if (err !== exp_err) begin n_errors++; $display("FAIL done_err got %b exp %b", err, exp_err); end
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL idle_after_done got req %b stall %b exp 0 0", mem_req, stall);
    end
    n_checks++;
    if (readdata !== exp_rd) begin n_errors++; $display("FAIL idle_hold_rd got %h exp %h", readdata, exp_rd); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'd0) begin
      n_errors++; $display("FAIL reset_bus got req %b we %b be %b exp 0 0 0", mem_req, mem_we, mem_be);
    end
    n_checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_errors++; $display("FAIL reset_data got addr %h wdata %h exp 0 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (readdata !== 32'd0 || err !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL reset_out got rd %h err %b stall %b exp 0 0 0", readdata, err, stall);
    end
  endtask

  task automatic test_loads();
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 3);
    do_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 1);
    do_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80123456, 2);
  endtask

  task automatic test_stores();
    do_access(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1);
    do_access(0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 2);
    do_access(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1);
  endtask

  task automatic test_illegal();
    do_access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1);
    do_reset();
    do_access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1);
    do_reset();
    do_access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1);
    do_access(1, 0, 3'b010, 32'h108, 32'h0, 32'h11223344, 1);
    do_reset();
  endtask

  task automatic test_timeout();
    do_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h55667788, 0);
    do_reset();
    do_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h55667788, TO);
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b1) begin n_errors++; $display("FAIL mid_busy_req got %b exp 1", mem_req); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || o_dbg_state !== 2'd0) begin
      n_errors++; $display("FAIL mid_reset got req %b stall %b state %0d exp 0 0 0", mem_req, stall, o_dbg_state);
    end
    memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; exp_rd = 32'd0; exp_err = 1'b0;
    do_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 1);
  endtask

  task automatic test_random();
    logic rd, wr;
    int sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 11);
      rd = (sel < 6) || (sel == 11);
      wr = (sel >= 6);
      do_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(1, TO + 1));
      if (exp_err && (i % 8 == 7)) do_reset();
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    exp_rd = 32'd0; exp_err = 1'b0;
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
